// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and types for the seven-segment scan controller
// Contents:
//   NUM_DIGITS    number of multiplexed digits on the board
//   ssd_state_t   scan FSM states
//   ANODE_OFF     all anodes dark (active-low)
//   CATHODE_OFF   all segments dark (active-low)
//   SEG_TABLE     hex nibble to active-low segment pattern, bit0 = a .. bit6 = g

package ssd_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } ssd_state_t;

    localparam logic [7:0] ANODE_OFF   = 8'hFF;
    localparam logic [6:0] CATHODE_OFF = 7'h7F;

    // Packed so that SEG_TABLE[n] selects the pattern for nibble n; the
    // concatenation is therefore listed from F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - combinational hex nibble to active-low segment decoder
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_seg     out 7  active-low segments, bit0 = a .. bit6 = g

module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - tear-free multiplexed scan driver for an 8-digit common-anode display
// Ports:
//   clk           in  1   system clock
//   reset         in  1   asynchronous active-low reset
//   enable        in  1   scan enable; low blanks the display
//   update_valid  in  1   new display data offered
//   update_ready  out 1   pending buffer empty, data can be accepted
//   digit_data    in  32  nibble k drives digit k (digit 0 rightmost)
//   digit_enable  in  8   bit k lights digit k
//   dp            in  8   bit k lights the decimal point of digit k
//   ssdAnode      out 8   active-low anodes, bit k = digit k
//   ssdCathode    out 7   active-low segments, bit0 = a .. bit6 = g
//   ssdDp         out 1   active-low decimal point
//   frame_done    out 1   one-cycle pulse at the end of the digit 7 slot

module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        update_valid,
    output logic        update_ready,
    input  logic [31:0] digit_data,
    input  logic [7:0]  digit_enable,
    input  logic [7:0]  dp,
    output logic [7:0]  ssdAnode,
    output logic [6:0]  ssdCathode,
    output logic        ssdDp,
    output logic        frame_done
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

    ssd_state_t   r_state;
    logic [IW-1:0] r_index;
    logic [CW-1:0] r_count;

    logic [31:0]  r_active_data;
    logic [7:0]   r_active_en;
    logic [7:0]   r_active_dp;

    logic [31:0]  r_pend_data;
    logic [7:0]   r_pend_en;
    logic [7:0]   r_pend_dp;
    logic         r_pend_full;

    logic [7:0]   r_anode;
    logic [6:0]   r_cathode;
    logic         r_dp;
    logic         r_frame_done;

    ssd_state_t   w_state_nxt;
    logic [IW-1:0] w_index_nxt;
    logic [CW-1:0] w_count_nxt;
    logic         w_load;
    logic         w_wrap;
    logic         w_accept;
    logic [31:0]  w_act_data_nxt;
    logic [7:0]   w_act_en_nxt;
    logic [7:0]   w_act_dp_nxt;
    logic [3:0]   w_nibble;
    logic [6:0]   w_seg;
    logic         w_lit;

    // Scan sequencing. Pending data is promoted to active only when a new
    // frame starts (leaving IDLE, or wrapping after digit 7), so a frame is
    // always rendered from a single consistent snapshot.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        w_wrap      = 1'b0;
        if (r_state != ST_IDLE && !enable) begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        w_state_nxt = ST_BLANK;
                        w_index_nxt = '0;
                        w_count_nxt = '0;
                        w_load      = r_pend_full;
                    end
                end
                ST_BLANK: begin
                    if (r_count == BLANK_LAST) begin
                        w_state_nxt = ST_DRIVE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (r_count == DRIVE_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_index_nxt = r_index + IW'(1);
                        w_count_nxt = '0;
                        if (r_index == INDEX_LAST) begin
                            w_wrap = 1'b1;
                            w_load = r_pend_full;
                        end
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_index_nxt = '0;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state view so that the pins change
    // on the same edge as the state and digit index.
    assign w_act_data_nxt = w_load ? r_pend_data : r_active_data;
    assign w_act_en_nxt   = w_load ? r_pend_en   : r_active_en;
    assign w_act_dp_nxt   = w_load ? r_pend_dp   : r_active_dp;
    assign w_nibble       = w_act_data_nxt[{w_index_nxt, 2'b00} +: 4];
    assign w_lit          = (w_state_nxt == ST_DRIVE) && w_act_en_nxt[w_index_nxt];

    // ready is low whenever pending is full, so a capture and a promotion
    // can never coincide.
    assign w_accept = update_valid && !r_pend_full;

    ssd_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_count       <= '0;
            r_active_data <= '0;
            r_active_en   <= '0;
            r_active_dp   <= '0;
            r_pend_data   <= '0;
            r_pend_en     <= '0;
            r_pend_dp     <= '0;
            r_pend_full   <= 1'b0;
            r_anode       <= ANODE_OFF;
            r_cathode     <= CATHODE_OFF;
            r_dp          <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_index       <= w_index_nxt;
            r_count       <= w_count_nxt;
            r_active_data <= w_act_data_nxt;
            r_active_en   <= w_act_en_nxt;
            r_active_dp   <= w_act_dp_nxt;
            if (w_accept) begin
                r_pend_data <= digit_data;
                r_pend_en   <= digit_enable;
                r_pend_dp   <= dp;
                r_pend_full <= 1'b1;
            end else if (w_load) begin
                r_pend_full <= 1'b0;
            end
            // A disabled digit still owns its full slot; it is simply dark.
            if (w_lit) begin
                r_anode   <= ~(8'h01 << w_index_nxt);
                r_cathode <= w_seg;
                r_dp      <= ~w_act_dp_nxt[w_index_nxt];
            end else begin
                r_anode   <= ANODE_OFF;
                r_cathode <= CATHODE_OFF;
                r_dp      <= 1'b1;
            end
            r_frame_done <= w_wrap;
        end
    end

    assign update_ready = ~r_pend_full;
    assign ssdAnode     = r_anode;
    assign ssdCathode   = r_cathode;
    assign ssdDp        = r_dp;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb/tb_ssd_scan_controller.sv - self-checking bench for ssd_scan_controller

module tb_ssd_scan_controller;

    localparam int DIGIT_CYCLES = 10;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME_CYCLES = 8 * DIGIT_CYCLES;
    localparam int LIT_CYCLES   = DIGIT_CYCLES - BLANK_CYCLES;

    // Active-low segment patterns, index = hex value, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] ca;
        logic       dp;
    } slot_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        update_valid;
    logic        update_ready;
    logic [31:0] digit_data;
    logic [7:0]  digit_enable;
    logic [7:0]  dp;
    logic [7:0]  ssdAnode;
    logic [6:0]  ssdCathode;
    logic        ssdDp;
    logic        frame_done;

    int    n_checks = 0;
    int    n_errors = 0;
    slot_t sb[$];
    bit    mon_on  = 0;
    bit    len_chk = 1;
    int    cyc     = 0;
    int    last_fd = -1;
    int    run_len = 0;
    logic [7:0] prev_an = 8'hFF;

    ssd_scan_controller #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .update_valid (update_valid),
        .update_ready (update_ready),
        .digit_data   (digit_data),
        .digit_enable (digit_enable),
        .dp           (dp),
        .ssdAnode     (ssdAnode),
        .ssdCathode   (ssdCathode),
        .ssdDp        (ssdDp),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        slot_t      s;
        logic [7:0] one;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) begin
                one  = 8'h01 << k;
                s.an = ~one;
                s.ca = SEG[d[4*k +: 4]];
                s.dp = ~p[k];
                sb.push_back(s);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic offer(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p,
                         output int waited, output bit fd_seen);
        digit_data   = d;
        digit_enable = e;
        dp           = p;
        update_valid = 1'b1;
        waited       = 0;
        while (!update_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        fd_seen = frame_done;
        if (waited >= 400) chk_eq("offer_timeout", 32'(waited), 32'd0);
        @(negedge clk);
        update_valid = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2 * FRAME_CYCLES);
        if (!frame_done) chk_eq("frame_done_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_anode(input logic [7:0] an);
        int n = 0;
        while (ssdAnode !== an && n < 2 * FRAME_CYCLES) begin
            @(negedge clk);
            n++;
        end
        if (ssdAnode !== an) chk_eq("wait_anode_timeout", 32'(ssdAnode), 32'(an));
    endtask

    task automatic start_scan(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        int w;
        bit f;
        sb.delete();
        enable = 1'b0;
        repeat (3) @(negedge clk);
        offer(d, e, p, w, f);
        push_frame(d, e, p);
        last_fd = -1;
        enable  = 1'b1;
    endtask

    // Slot monitor: each lit run is matched against the next scoreboard entry,
    // its length is checked, dark cycles must be fully dark, and frame_done
    // spacing must equal one frame.
    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            if (frame_done) begin
                if (last_fd >= 0) chk_eq("frame_period", 32'(cyc - last_fd), 32'(FRAME_CYCLES));
                last_fd = cyc;
            end
            if (ssdAnode !== 8'hFF) begin
                if (prev_an === 8'hFF) begin
                    if (sb.size() == 0) begin
                        chk_eq("unexpected_slot", 32'(ssdAnode), 32'hFF);
                    end else begin
                        slot_t e;
                        e = sb.pop_front();
                        chk_eq("slot_anode", 32'(ssdAnode), 32'(e.an));
                        chk_eq("slot_cathode", 32'(ssdCathode), 32'(e.ca));
                        chk_eq("slot_dp", 32'(ssdDp), 32'(e.dp));
                    end
                end else begin
                    chk_eq("slot_stable", 32'(ssdAnode), 32'(prev_an));
                end
                run_len++;
            end else begin
                chk_eq("dark_outputs", {24'd0, ssdCathode, ssdDp}, {24'd0, 7'h7F, 1'b1});
                if (prev_an !== 8'hFF && len_chk) chk_eq("slot_length", 32'(run_len), 32'(LIT_CYCLES));
                run_len = 0;
            end
            prev_an = ssdAnode;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        int   w;
        bit   f;
        int   n;

        vecs[0] = '{32'h76543210, 8'hFF, 8'h00};
        vecs[1] = '{32'hFEDCBA98, 8'hFF, 8'hA5};
        vecs[2] = '{32'h76543210, 8'b0000_0011, 8'b0000_0010};
        vecs[3] = '{32'h88888888, 8'hFF, 8'h00};
        vecs[4] = '{32'h9ABC1E0F, 8'h81, 8'h7E};

        reset        = 1'b0;
        enable       = 1'b0;
        update_valid = 1'b0;
        digit_data   = '0;
        digit_enable = '0;
        dp           = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk_eq("rst_anode", 32'(ssdAnode), 32'hFF);
        chk_eq("rst_cathode", 32'(ssdCathode), 32'h7F);
        chk_eq("rst_dp", 32'(ssdDp), 32'd1);
        chk_eq("rst_ready", 32'(update_ready), 32'd1);
        chk_eq("rst_frame_done", 32'(frame_done), 32'd0);
        reset  = 1'b1;
        mon_on = 1'b1;

        // Dropped valid without a handshake has no effect.
        update_valid = 1'b1;
        digit_data   = 32'h11111111;
        digit_enable = 8'hFF;
        update_valid = 1'b0;
        @(negedge clk);
        chk_eq("no_xfer_ready", 32'(update_ready), 32'd1);

        // Table-driven frames: one vector shown per frame, each offered at
        // the start of the preceding frame.
        start_scan(vecs[0].data, vecs[0].en, vecs[0].dp);
        for (int i = 1; i < 5; i++) begin
            offer(vecs[i].data, vecs[i].en, vecs[i].dp, w, f);
            push_frame(vecs[i].data, vecs[i].en, vecs[i].dp);
            wait_fd();
        end
        wait_fd();
        enable = 1'b0;
        chk_eq("table_sb_empty", 32'(sb.size()), 32'd0);

        // Tear-free update offered during digit 3.
        start_scan(32'hFEDCBA98, 8'hFF, 8'h00);
        wait_anode(8'hF7);
        chk_eq("tear_ready_before", 32'(update_ready), 32'd1);
        offer(32'h88888888, 8'hFF, 8'h00, w, f);
        chk_eq("tear_ready_fall", 32'(update_ready), 32'd0);
        push_frame(32'h88888888, 8'hFF, 8'h00);
        wait_fd();
        chk_eq("tear_ready_after_wrap", 32'(update_ready), 32'd1);
        wait_fd();
        enable = 1'b0;
        chk_eq("tear_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: second update held until the wrap, accepted the cycle after.
        start_scan(32'h13579BDF, 8'hFF, 8'h0F);
        offer(32'h2468ACE0, 8'hFF, 8'hF0, w, f);
        push_frame(32'h2468ACE0, 8'hFF, 8'hF0);
        offer(32'hDEADBEEF, 8'h5A, 8'h3C, w, f);
        chk_eq("bp_accept_after_wrap", 32'(f), 32'd1);
        chk_eq("bp_held_long", 32'(w > 60), 32'd1);
        chk_eq("bp_ready_low", 32'(update_ready), 32'd0);
        push_frame(32'hDEADBEEF, 8'h5A, 8'h3C);
        wait_fd();
        wait_fd();
        enable = 1'b0;
        chk_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Enable drop during digit 5, then restart from digit 0.
        start_scan(32'h01234567, 8'hFF, 8'h20);
        wait_anode(8'hDF);
        len_chk = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        chk_eq("drop_anode", 32'(ssdAnode), 32'hFF);
        chk_eq("drop_cathode", 32'(ssdCathode), 32'h7F);
        chk_eq("drop_dp", 32'(ssdDp), 32'd1);
        sb.delete();
        repeat (4) @(negedge clk);
        len_chk = 1'b1;
        push_frame(32'h01234567, 8'hFF, 8'h20);
        last_fd = -1;
        enable  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ssdAnode === 8'hFF && n < 20);
        chk_eq("restart_latency", 32'(n), 32'(BLANK_CYCLES + 1));
        chk_eq("restart_digit0", 32'(ssdAnode), 32'hFE);
        wait_fd();
        enable = 1'b0;
        chk_eq("drop_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset between edges discards pending and active data.
        start_scan(32'h55555555, 8'hFF, 8'hFF);
        offer(32'h33333333, 8'hFF, 8'h00, w, f);
        wait_anode(8'hFB);
        len_chk = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_eq("areset_anode", 32'(ssdAnode), 32'hFF);
        chk_eq("areset_cathode", 32'(ssdCathode), 32'h7F);
        chk_eq("areset_dp", 32'(ssdDp), 32'd1);
        chk_eq("areset_ready", 32'(update_ready), 32'd1);
        sb.delete();
        last_fd = -1;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 2 * FRAME_CYCLES + 10; c++) begin
            @(negedge clk);
            if (ssdAnode !== 8'hFF) n++;
        end
        chk_eq("areset_nothing_lit", 32'(n), 32'd0);
        chk_eq("areset_ready_after", 32'(update_ready), 32'd1);
        enable  = 1'b0;
        len_chk = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
